// File: rtl/core_io_bridge_pkg.sv
// Shared types and defaults for the core I/O bridge.
// Contents: reset-sequencer FSM state type, channel-select width helper,
// and the default parameter values used by core_io_bridge.
package core_io_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int unsigned DEF_IN_W     = 3;
    localparam int unsigned DEF_OUT_W    = 8;
    localparam int unsigned DEF_N_CH     = 2;
    localparam int unsigned DEF_RST_HOLD = 4;
    localparam int unsigned DEF_SYNC_STG = 2;
    localparam int unsigned DEF_DEB_CYC  = 8;

    // Width of the channel-select bus; a single channel still gets one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_io_bridge_io_sync.sv
// io_sync: multi-bit flop-chain synchroniser with asynchronous active-high
// reset. Output is the last stage; latency is STAGES clock edges.
module io_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the raw input through the synchroniser stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/core_io_bridge.sv
// core_io_bridge: reset sequencer and I/O port between board pins and the core.
// Holds core_nrst low for RST_HOLD cycles after rst, synchronises ext_in,
// flags input changes, and registers core writes into N_CH output channels.
// Optional feature: define IO_DEBOUNCE_EN to add a DEB_CYC-cycle debounce
// stage after the synchroniser.
module core_io_bridge
    import core_io_pkg::*;
#(
    parameter int unsigned IN_W     = DEF_IN_W,
    parameter int unsigned OUT_W    = DEF_OUT_W,
    parameter int unsigned N_CH     = DEF_N_CH,
    parameter int unsigned RST_HOLD = DEF_RST_HOLD,
    parameter int unsigned SYNC_STG = DEF_SYNC_STG,
    parameter int unsigned DEB_CYC  = DEF_DEB_CYC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_W-1:0]             ext_in,
    output logic                        core_nrst,
    output logic [IN_W-1:0]             core_in,
    output logic                        in_chg,
    input  logic [OUT_W-1:0]            core_out,
    input  logic                        core_we,
    input  logic [sel_width(N_CH)-1:0]  core_sel,
    output logic [N_CH*OUT_W-1:0]       out_bus,
    output logic [N_CH-1:0]             out_upd
);

    localparam int unsigned SEL_W  = sel_width(N_CH);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IN_W-1:0]   sync_q;
    logic [IN_W-1:0]   prev_in;

    io_sync #(
        .WIDTH  (IN_W),
        .STAGES (SYNC_STG)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_in),
        .q   (sync_q)
    );

    // Reset sequencer: release core_nrst RST_HOLD+1 edges after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            hold_cnt  <= '0;
            core_nrst <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_HOLD;
                    hold_cnt <= '0;
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        state     <= S_RUN;
                        hold_cnt  <= '0;
                        core_nrst <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    core_nrst <= 1'b1;
                end
                default: begin
                    state     <= S_RESET;
                    core_nrst <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);

    logic [IN_W-1:0]  sync_last;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_next;

    // Length of the current run of identical synchronised values, saturating at DEB_CYC.
    always_comb begin
        deb_next = deb_cnt;
        if (sync_q != sync_last) begin
            deb_next = DEB_W'(1);
        end else if (deb_cnt != DEB_W'(DEB_CYC)) begin
            deb_next = deb_cnt + DEB_W'(1);
        end
    end

    // Pass the synchronised value on once it has held for DEB_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_last <= '0;
            deb_cnt   <= '0;
            core_in   <= '0;
        end else begin
            sync_last <= sync_q;
            deb_cnt   <= deb_next;
            if (deb_next == DEB_W'(DEB_CYC)) begin
                core_in <= sync_q;
            end
        end
    end
`else
    assign core_in = sync_q;
`endif

    // Change detect: pulse one cycle after core_in takes a new value, run state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_in <= '0;
            in_chg  <= 1'b0;
        end else begin
            prev_in <= core_in;
            in_chg  <= (state == S_RUN) && (core_in != prev_in);
        end
    end

    // Output channels: accept in-range writes in run state and pulse that channel's update flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_bus <= '0;
            out_upd <= '0;
        end else begin
            out_upd <= '0;
            if ((state == S_RUN) && core_we) begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (core_sel == SEL_W'(k)) begin
                        out_bus[k*OUT_W +: OUT_W] <= core_out;
                        out_upd[k]                <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_core_io_bridge.sv
// Self-checking bench for core_io_bridge. A behavioural model tracks edges
// since reset release, the ext_in sample history and the channel contents,
// and every cycle's outputs are compared against it. N_CH=3 so that an
// out-of-range select value exists on the 2-bit select bus.
module tb_core_io_bridge;
    import core_io_pkg::*;

    localparam int IN_W     = 3;
    localparam int OUT_W    = 8;
    localparam int N_CH     = 3;
    localparam int RST_HOLD = 4;
    localparam int SYNC_STG = 2;
    localparam int DEB_CYC  = 8;
    localparam int SEL_W    = sel_width(N_CH);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [IN_W-1:0]       ext_in = '0;
    logic                  core_nrst;
    logic [IN_W-1:0]       core_in;
    logic                  in_chg;
    logic [OUT_W-1:0]      core_out = '0;
    logic                  core_we = 1'b0;
    logic [SEL_W-1:0]      core_sel = '0;
    logic [N_CH*OUT_W-1:0] out_bus;
    logic [N_CH-1:0]       out_upd;

    core_io_bridge #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .N_CH     (N_CH),
        .RST_HOLD (RST_HOLD),
        .SYNC_STG (SYNC_STG),
        .DEB_CYC  (DEB_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_in    (ext_in),
        .core_nrst (core_nrst),
        .core_in   (core_in),
        .in_chg    (in_chg),
        .core_out  (core_out),
        .core_we   (core_we),
        .core_sel  (core_sel),
        .out_bus   (out_bus),
        .out_upd   (out_upd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int                    edges;
    logic [IN_W-1:0]       samp[$];
    logic [IN_W-1:0]       s_hist[$];
    logic [IN_W-1:0]       ci1, ci2;
    logic                  exp_nrst, exp_chg;
    logic [N_CH*OUT_W-1:0] exp_bus;
    logic [N_CH-1:0]       exp_upd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("core_nrst", 64'(core_nrst), 64'(exp_nrst));
        check("core_in",   64'(core_in),   64'(ci1));
        check("in_chg",    64'(in_chg),    64'(exp_chg));
        check("out_bus",   64'(out_bus),   64'(exp_bus));
        check("out_upd",   64'(out_upd),   64'(exp_upd));
    endtask

    task automatic model_reset();
        edges = 0;
        samp.delete();
        s_hist.delete();
        ci1 = '0;
        ci2 = '0;
        exp_nrst = 1'b0;
        exp_chg  = 1'b0;
        exp_bus  = '0;
        exp_upd  = '0;
    endtask

    // Synchronised value visible after edge k (zero before/at reset).
    function automatic logic [IN_W-1:0] get_s(input int k);
        if (k < 1 || k > s_hist.size()) return '0;
        return s_hist[k-1];
    endfunction

    // One clock edge: advance the model with the inputs the DUT just sampled, then compare.
    task automatic step();
        bit              run_b;
        bit              stable;
        logic [IN_W-1:0] s_now;
        logic [IN_W-1:0] new_ci;
        @(posedge clk);
        run_b = (edges >= RST_HOLD + 1);
        edges++;
        samp.push_back(ext_in);
        s_now = (edges - SYNC_STG >= 0) ? samp[edges-SYNC_STG] : '0;
        s_hist.push_back(s_now);
`ifdef IO_DEBOUNCE_EN
        stable = 1'b1;
        for (int k = edges - DEB_CYC; k <= edges - 1; k++) begin
            if (get_s(k) != get_s(edges - 1)) stable = 1'b0;
        end
        new_ci = stable ? get_s(edges - 1) : ci1;
`else
        stable = 1'b1;
        new_ci = s_now;
`endif
        exp_chg = run_b && (ci1 != ci2);
        ci2 = ci1;
        ci1 = new_ci;
        exp_upd = '0;
        if (run_b && core_we && (int'(core_sel) < N_CH)) begin
            exp_bus[int'(core_sel)*OUT_W +: OUT_W] = core_out;
            exp_upd[core_sel] = 1'b1;
        end
        exp_nrst = (edges >= RST_HOLD + 1);
        #1;
        check_all();
    endtask

    task automatic random_phase(input int cycles);
        int hold_left = 0;
        for (int i = 0; i < cycles; i++) begin
            if (hold_left == 0) begin
                ext_in    = IN_W'($urandom);
                hold_left = $urandom_range(1, 14);
            end
            hold_left--;
            core_we  = 1'($urandom_range(0, 1));
            core_sel = SEL_W'($urandom_range(0, 3));
            core_out = OUT_W'($urandom);
            step();
        end
        core_we = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset state while rst is held
        @(posedge clk);
        #1 check_all();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Hold sequence; writes attempted before run must be ignored
        core_we  = 1'b1;
        core_sel = SEL_W'(1);
        core_out = 8'h3C;
        repeat (4) step();
        core_we = 1'b0;
        repeat (6) step();

        // Input change in run state
        ext_in = 3'b010;
        repeat (SYNC_STG + DEB_CYC + 3) step();

        // Channel 0 then channel 1 writes
        core_sel = SEL_W'(0); core_out = 8'h5A; core_we = 1'b1; step();
        core_we = 1'b0; step();
        core_sel = SEL_W'(1); core_out = 8'hA5; core_we = 1'b1; step();
        core_we = 1'b0; step(); step();

        // Out-of-range select is dropped
        core_sel = '1; core_out = 8'hFF; core_we = 1'b1; step();
        core_we = 1'b0; step();

        // Back-to-back writes to one channel
        core_sel = SEL_W'(2); core_we = 1'b1;
        core_out = 8'h11; step();
        core_out = 8'h22; step();
        core_out = 8'h33; step();
        core_we = 1'b0; step();

        // Short glitch then a longer level on ext_in
        ext_in = 3'b000; repeat (12) step();
        ext_in = 3'b101; repeat (5) step();
        ext_in = 3'b000; repeat (12) step();
        ext_in = 3'b110; repeat (10) step();
        repeat (12) step();

        random_phase(300);

        // Asynchronous reset pulse between edges
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        core_we = 1'b1; core_sel = SEL_W'(0); core_out = 8'h77;
        repeat (10) step();
        core_we = 1'b0;
        random_phase(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
